nps_rom_arb: RTL and testbench
==============================

NPS_ROM_ARB -- requirements
Module: nps_rom_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, ROM word width.
REQ-002 SHALL have parameter ADR_WIDTH, default 9, ROM address width (512 words).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_x  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req_a / req_b  in  1  requester wants one frame of ROM access.
REQ-006 SHALL have ports gnt_a / gnt_b  out  1  requester owns the ROM input side.
REQ-007 SHALL have ports vi_a / vi_b  in  1  address valid from requester.
REQ-008 SHALL have ports fi_a / fi_b  in  1  end-of-frame level from requester.
REQ-009 SHALL have ports adr_a / adr_b  in  ADR_WIDTH  lookup address.
REQ-010 SHALL have ports vo_a / vo_b  out  1  returned data valid.
REQ-011 SHALL have ports fo_a / fo_b  out  1  frame-done pulse.
REQ-012 SHALL have ports datao_a / datao_b  out  DATA_WIDTH  returned ROM word.
REQ-013 SHALL have ports rom_vi, rom_fi  out  1, and rom_adr  out  ADR_WIDTH; these drive the ROM vi, fi and datai inputs.
REQ-014 SHALL have ports rom_vo, rom_fo  in  1, and rom_datao  in  DATA_WIDTH; these come from the ROM vo, fo and datao outputs.
REQ-015 SHALL have port busy  out  1  high whenever the state is not IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, OWN and DRAIN, plus a 1-bit owner register and a 1-bit last-served register.
REQ-017 In IDLE, with any req high, SHALL pick the owner, assert that requester's gnt and enter OWN on the next edge.
- Only one req high: that requester becomes owner.
- Both req high: the requester other than last-served becomes owner.
REQ-018 In OWN, SHALL register the owner's vi, adr and fi onto rom_vi, rom_adr and rom_fi with 1-cycle latency; the non-owner's vi, fi and adr SHALL be ignored.
REQ-019 An owner vi and fi high in the same cycle SHALL forward both the address and fi.
REQ-020 On the first owner fi=1 in OWN, SHALL deassert gnt and enter DRAIN at the same edge.
REQ-021 In DRAIN, SHALL hold rom_fi=1 and rom_vi=0 until rom_fo=1 is sampled.
REQ-022 When rom_fo=1 is sampled in DRAIN, SHALL on that edge:
- pulse the owner's fo for exactly 1 cycle;
- set last-served to the owner;
- drop rom_fi;
- return to IDLE.
REQ-023 Returned data SHALL be routed with 1-cycle registered latency: rom_vo/rom_datao -> owner's vo/datao while in OWN or DRAIN, including the rom_fo cycle.
REQ-024 The non-owner's vo SHALL be 0 and its datao SHALL be 0.
REQ-025 rom_vo or rom_fo arriving in IDLE SHALL be dropped, with no output effect.
REQ-026 A req deasserted while in OWN SHALL NOT end the frame; only fi ends it.
REQ-027 rom_adr SHALL hold its last value when rom_vi=0.

Reset
REQ-028 While reset_x=0, SHALL asynchronously force:
- state=IDLE, owner=A, last-served=B (A wins the first tie);
- all gnt, vo, fo, rom_vi, rom_fi and busy = 0;
- all datao and rom_adr = 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; the stale rom_vo/rom_fo seen after release SHALL be dropped per REQ-025.

Structure
REQ-030 Package nps_rom_pkg SHALL hold the DATA_WIDTH/ADR_WIDTH defaults and the FSM state encoding.
REQ-031 The owner-selection logic SHALL be the sub-module nps_rom_rr (inputs req_a, req_b, last; outputs valid, pick).
REQ-032 The remainder of the block SHALL be a single module, estimated 150-250 lines.

Verification
REQ-033 Reset release, then req_a only, then adr_a 0..511 with vi_a, then fi_a -> the scenario SHALL show all of:
- gnt_a one cycle after req_a;
- rom_adr = 0..511 with 1-cycle lag;
- vo_a/datao_a carry every ROM word and vo_b stays 0;
- fo_a pulses once;
- busy falls to 0.
REQ-034 req_a and req_b both high after reset -> A SHALL be served first; B SHALL get gnt_b only after fo_a; with both still requesting, the next frame SHALL go to A again.
REQ-035 vi_b with adr_b=5 while A owns -> rom_adr SHALL never show 5 during A's frame, and no vo_b SHALL occur.
REQ-036 vi_a with fi_a on the same cycle, adr_a=511 -> rom_adr=511 with rom_vi=1 and rom_fi=1 on the next cycle; the FSM SHALL enter DRAIN.
REQ-037 reset_x low during DRAIN, then a rom_fo pulse after release -> no fo_a/fo_b, state SHALL stay IDLE.
REQ-038 Spurious rom_vo=1 with rom_datao=24'hABCDEF in IDLE -> vo_a=vo_b=0 and datao_a=datao_b=0.

Source files
------------

// File: rtl/nps_rom_pkg.sv
// Shared widths and FSM encoding for the two-port ROM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nps_rom_pkg;

  localparam int DATA_WIDTH_DEF = 24;
  localparam int ADR_WIDTH_DEF  = 9;

  // Owner / last-served encoding: 0 = requester A, 1 = requester B.
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/nps_rom_rr.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the side not served last.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module nps_rom_rr
  import nps_rom_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic valid,
  output logic pick
);

  // Tie-break on the last-served side; otherwise follow the single request.
  always_comb begin
    valid = req_a | req_b;
    pick  = (req_a & req_b) ? ~last : (req_b ? OWN_B : OWN_A);
  end

endmodule

// File: rtl/nps_rom_arb.sv
// Shares one ROM lookup port between requesters A and B, one whole frame at a time.
// Latency: 1 cycle requester->ROM (vi/fi/adr) and 1 cycle ROM->requester (vo/datao/fo).
// Backpressure: none on data; requesters wait for gnt, and a frame closes only once the ROM returns fo.
module nps_rom_arb
  import nps_rom_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADR_WIDTH  = ADR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_x,
  input  logic                  req_a,
  input  logic                  req_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  input  logic                  vi_a,
  input  logic                  vi_b,
  input  logic                  fi_a,
  input  logic                  fi_b,
  input  logic [ADR_WIDTH-1:0]  adr_a,
  input  logic [ADR_WIDTH-1:0]  adr_b,
  output logic                  vo_a,
  output logic                  vo_b,
  output logic                  fo_a,
  output logic                  fo_b,
  output logic [DATA_WIDTH-1:0] datao_a,
  output logic [DATA_WIDTH-1:0] datao_b,
  output logic                  rom_vi,
  output logic                  rom_fi,
  output logic [ADR_WIDTH-1:0]  rom_adr,
  input  logic                  rom_vo,
  input  logic                  rom_fo,
  input  logic [DATA_WIDTH-1:0] rom_datao,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  rom_vi_q, rom_vi_d;
  logic                  rom_fi_q, rom_fi_d;
  logic [ADR_WIDTH-1:0]  rom_adr_q, rom_adr_d;
  logic                  vo_a_q, vo_a_d, vo_b_q, vo_b_d;
  logic                  fo_a_q, fo_a_d, fo_b_q, fo_b_d;
  logic [DATA_WIDTH-1:0] datao_a_q, datao_a_d, datao_b_q, datao_b_d;

  logic                  rr_valid, rr_pick;
  logic                  own_vi, own_fi;
  logic [ADR_WIDTH-1:0]  own_adr;

  nps_rom_rr u_rr (
    .req_a (req_a),
    .req_b (req_b),
    .last  (last_q),
    .valid (rr_valid),
    .pick  (rr_pick)
  );

  // Select the current owner's request side; the other side is never looked at.
  always_comb begin
    own_vi  = (owner_q == OWN_B) ? vi_b  : vi_a;
    own_fi  = (owner_q == OWN_B) ? fi_b  : fi_a;
    own_adr = (owner_q == OWN_B) ? adr_b : adr_a;
  end

  // Next-state and registered-output computation for the frame FSM.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rom_vi_d  = rom_vi_q;
    rom_fi_d  = rom_fi_q;
    rom_adr_d = rom_adr_q;
    vo_a_d    = 1'b0;
    vo_b_d    = 1'b0;
    fo_a_d    = 1'b0;
    fo_b_d    = 1'b0;
    datao_a_d = '0;
    datao_b_d = '0;

    case (state_q)
      ST_IDLE: begin
        rom_vi_d = 1'b0;
        rom_fi_d = 1'b0;
        if (rr_valid) begin
          owner_d = rr_pick;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        // Address and fi travel together, so a vi+fi cycle forwards both.
        rom_vi_d = own_vi;
        rom_fi_d = own_fi;
        if (own_vi) rom_adr_d = own_adr;
        if (own_fi) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Keep fi asserted toward the ROM until it confirms the frame end.
        rom_vi_d = 1'b0;
        rom_fi_d = 1'b1;
        if (rom_fo) begin
          rom_fi_d = 1'b0;
          last_d   = owner_q;
          fo_a_d   = (owner_q == OWN_A);
          fo_b_d   = (owner_q == OWN_B);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Return path is live through OWN and DRAIN (including the fo cycle); IDLE drops it.
    if (state_q != ST_IDLE) begin
      if (owner_q == OWN_A) begin
        vo_a_d    = rom_vo;
        datao_a_d = rom_datao;
      end else begin
        vo_b_d    = rom_vo;
        datao_b_d = rom_datao;
      end
    end
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_A;
      last_q    <= OWN_B;
      rom_vi_q  <= 1'b0;
      rom_fi_q  <= 1'b0;
      rom_adr_q <= '0;
      vo_a_q    <= 1'b0;
      vo_b_q    <= 1'b0;
      fo_a_q    <= 1'b0;
      fo_b_q    <= 1'b0;
      datao_a_q <= '0;
      datao_b_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      rom_vi_q  <= rom_vi_d;
      rom_fi_q  <= rom_fi_d;
      rom_adr_q <= rom_adr_d;
      vo_a_q    <= vo_a_d;
      vo_b_q    <= vo_b_d;
      fo_a_q    <= fo_a_d;
      fo_b_q    <= fo_b_d;
      datao_a_q <= datao_a_d;
      datao_b_q <= datao_b_d;
    end
  end

  assign gnt_a   = (state_q == ST_OWN) && (owner_q == OWN_A);
  assign gnt_b   = (state_q == ST_OWN) && (owner_q == OWN_B);
  assign busy    = (state_q != ST_IDLE);
  assign rom_vi  = rom_vi_q;
  assign rom_fi  = rom_fi_q;
  assign rom_adr = rom_adr_q;
  assign vo_a    = vo_a_q;
  assign vo_b    = vo_b_q;
  assign fo_a    = fo_a_q;
  assign fo_b    = fo_b_q;
  assign datao_a = datao_a_q;
  assign datao_b = datao_b_q;

endmodule

// File: tb/tb_nps_rom_arb.sv
// Bench for nps_rom_arb: cycle vector table, reset corner cases, and randomized frames
// checked against a transaction-level model (round-robin order, address stream, ROM words).
module tb_nps_rom_arb;

  localparam int DW = 24;
  localparam int AW = 9;
  localparam logic [DW-1:0] SPUR = 24'hABCDEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_x;
  logic          req_a, req_b, vi_a, vi_b, fi_a, fi_b;
  logic [AW-1:0] adr_a, adr_b;
  logic          gnt_a, gnt_b, vo_a, vo_b, fo_a, fo_b, busy;
  logic [DW-1:0] datao_a, datao_b;
  logic          rom_vi, rom_fi, rom_vo, rom_fo;
  logic [AW-1:0] rom_adr;
  logic [DW-1:0] rom_datao;

  // ROM side: either a behavioural ROM (auto) or values forced by the test.
  logic          rom_auto = 1'b0;
  logic          man_vo = 1'b0, man_fo = 1'b0;
  logic [DW-1:0] man_dat = '0;
  logic          auto_vo = 1'b0, auto_fo = 1'b0;
  logic [DW-1:0] auto_dat = '0;
  int            fi_cnt = 0;
  int            fo_delay = 1;

  assign rom_vo    = rom_auto ? auto_vo  : man_vo;
  assign rom_fo    = rom_auto ? auto_fo  : man_fo;
  assign rom_datao = rom_auto ? auto_dat : man_dat;

  nps_rom_arb #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) dut (
    .clk(clk), .reset_x(reset_x),
    .req_a(req_a), .req_b(req_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .vi_a(vi_a), .vi_b(vi_b), .fi_a(fi_a), .fi_b(fi_b),
    .adr_a(adr_a), .adr_b(adr_b),
    .vo_a(vo_a), .vo_b(vo_b), .fo_a(fo_a), .fo_b(fo_b),
    .datao_a(datao_a), .datao_b(datao_b),
    .rom_vi(rom_vi), .rom_fi(rom_fi), .rom_adr(rom_adr),
    .rom_vo(rom_vo), .rom_fo(rom_fo), .rom_datao(rom_datao),
    .busy(busy)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return DW'(a) * DW'(40503) + DW'(24'h00C0DE);
  endfunction

  // Behavioural ROM: word one cycle after vi; fo once fi has been seen fo_delay cycles.
  always @(posedge clk) begin
    logic          s_vi, s_fi;
    logic [AW-1:0] s_adr;
    s_vi  = rom_vi;
    s_fi  = rom_fi;
    s_adr = rom_adr;
    #1;
    auto_vo  = s_vi;
    auto_dat = s_vi ? rom_word(s_adr) : '0;
    if (s_fi) fi_cnt = fi_cnt + 1;
    else      fi_cnt = 0;
    auto_fo  = s_fi && (fi_cnt == fo_delay);
  end

  // Observed traffic, recorded once per cycle.
  logic [AW-1:0] obs_adr[$];
  logic [DW-1:0] obs_a[$], obs_b[$];
  int            fo_cnt_a = 0, fo_cnt_b = 0;

  always @(negedge clk) begin
    if (rom_vi) obs_adr.push_back(rom_adr);
    if (vo_a)   obs_a.push_back(datao_a);
    if (vo_b)   obs_b.push_back(datao_b);
    if (fo_a)   fo_cnt_a = fo_cnt_a + 1;
    if (fo_b)   fo_cnt_b = fo_cnt_b + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit model_last = 1'b1;  // side served last: 0=A, 1=B

  task automatic chk(input bit ok, input string name, input string detail);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  typedef struct packed {
    logic ra, rb, via, fia;
    logic [AW-1:0] adra;
    logic vib, fib;
    logic [AW-1:0] adrb;
    logic rvo, rfo;
  } vin_t;

  typedef struct packed {
    logic ga, gb, rvi, rfi;
    logic [AW-1:0] radr;
    logic busy, voa, vob, foa, fob;
  } vout_t;

  typedef struct packed {
    vin_t  i;
    vout_t o;
  } vec_t;

  function automatic vec_t mkv(input logic [3:0] a4, input logic [AW-1:0] adra,
                               input logic [1:0] b2, input logic [AW-1:0] adrb,
                               input logic [1:0] r2, input logic [3:0] o4,
                               input logic [AW-1:0] radr, input logic [4:0] o5);
    return {a4, adra, b2, adrb, r2, o4, radr, o5};
  endfunction

  function automatic vout_t sample_out();
    return {gnt_a, gnt_b, rom_vi, rom_fi, rom_adr, busy, vo_a, vo_b, fo_a, fo_b};
  endfunction

  task automatic clear_inputs();
    req_a = 0; req_b = 0; vi_a = 0; vi_b = 0; fi_a = 0; fi_b = 0;
    adr_a = '0; adr_b = '0;
    man_vo = 0; man_fo = 0; man_dat = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_x = 1'b0;
    repeat (2) step();
    reset_x = 1'b1;
    model_last = 1'b1;
    step();
  endtask

  // Owner gets the requested values; the other side gets random noise that must be ignored.
  task automatic drive_owner(input bit win, input bit v, input bit f, input logic [AW-1:0] a);
    logic [AW-1:0] g;
    g = AW'($urandom_range(0, 511));
    if (win) begin
      vi_b = v; fi_b = f; adr_b = a; req_b = 1'($urandom_range(0, 1));
      vi_a = 1'($urandom_range(0, 1)); fi_a = 1'($urandom_range(0, 1));
      adr_a = g; req_a = 1'($urandom_range(0, 1));
    end else begin
      vi_a = v; fi_a = f; adr_a = a; req_a = 1'($urandom_range(0, 1));
      vi_b = 1'($urandom_range(0, 1)); fi_b = 1'($urandom_range(0, 1));
      adr_b = g; req_b = 1'($urandom_range(0, 1));
    end
  endtask

  // One whole frame with the behavioural ROM; expectations come from the arbitration rule.
  task automatic run_frame(input bit ra, input bit rb, input int n, input bit contig);
    bit            win, same_fi, done;
    int            bad;
    logic [AW-1:0] a;
    logic [AW-1:0] exp_adr[$];
    logic [DW-1:0] exp_dat[$];
    logic [DW-1:0] got_dat[$];
    logic [DW-1:0] leak[$];

    win = (ra && rb) ? !model_last : rb;
    fo_delay = $urandom_range(1, 4);
    obs_adr.delete(); obs_a.delete(); obs_b.delete();
    fo_cnt_a = 0; fo_cnt_b = 0;

    chk(!busy && !gnt_a && !gnt_b, "pre_idle",
        $sformatf("busy=%b gnt_a=%b gnt_b=%b required 0/0/0", busy, gnt_a, gnt_b));
    req_a = ra; req_b = rb;
    step();
    chk(gnt_a == !win && gnt_b == win, "gnt",
        $sformatf("gnt_a=%b gnt_b=%b required %b/%b", gnt_a, gnt_b, !win, win));

    same_fi = contig ? 1'b0 : 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) begin
      if (!contig) begin
        while ($urandom_range(0, 2) == 0) begin
          drive_owner(win, 1'b0, 1'b0, '0);
          step();
        end
      end
      a = contig ? AW'(i) : AW'($urandom_range(0, 511));
      drive_owner(win, 1'b1, (i == n - 1) && same_fi, a);
      exp_adr.push_back(a);
      exp_dat.push_back(rom_word(a));
      step();
    end
    if (!same_fi) begin
      drive_owner(win, 1'b0, 1'b1, '0);
      step();
    end
    clear_inputs();

    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      step();
      if (!busy) done = 1'b1;
    end
    step();
    step();

    chk(done, "drain_done", $sformatf("busy=%b after 64 cycles, required 0", busy));

    bad = (obs_adr.size() == exp_adr.size()) ? -1 : -2;
    for (int i = 0; i < exp_adr.size() && bad == -1; i++)
      if (obs_adr[i] !== exp_adr[i]) bad = i;
    chk(bad == -1, "adr_stream",
        $sformatf("count=%0d required %0d, first bad idx=%0d", obs_adr.size(), exp_adr.size(), bad));

    got_dat = win ? obs_b : obs_a;
    leak    = win ? obs_a : obs_b;
    bad = (got_dat.size() == exp_dat.size()) ? -1 : -2;
    for (int i = 0; i < exp_dat.size() && bad == -1; i++)
      if (got_dat[i] !== exp_dat[i]) bad = i;
    chk(bad == -1, "data_stream",
        $sformatf("count=%0d required %0d, first bad idx=%0d", got_dat.size(), exp_dat.size(), bad));
    chk(leak.size() == 0, "data_leak",
        $sformatf("non-owner vo count=%0d required 0", leak.size()));
    chk((win ? fo_cnt_b : fo_cnt_a) == 1 && (win ? fo_cnt_a : fo_cnt_b) == 0, "fo_pulse",
        $sformatf("fo_a=%0d fo_b=%0d required owner=1 other=0 (owner %s)",
                  fo_cnt_a, fo_cnt_b, win ? "B" : "A"));
    model_last = win;
  endtask

  vec_t          vecs[13];
  vout_t         got;
  logic [DW-1:0] exp_da, exp_db;

  initial begin
    // Rows: {ra,rb,via,fia}, adr_a, {vib,fib}, adr_b, {rom_vo,rom_fo} |
    //       {gnt_a,gnt_b,rom_vi,rom_fi}, rom_adr, {busy,vo_a,vo_b,fo_a,fo_b} after the next edge.
    vecs[0]  = mkv(4'b0000, 9'd0,   2'b00, 9'd0, 2'b11, 4'b0000, 9'd0,   5'b00000); // stray ROM output in IDLE
    vecs[1]  = mkv(4'b1100, 9'd0,   2'b00, 9'd0, 2'b00, 4'b1000, 9'd0,   5'b10000); // tie after reset -> A
    vecs[2]  = mkv(4'b1110, 9'd3,   2'b10, 9'd5, 2'b00, 4'b1010, 9'd3,   5'b10000); // B's adr 5 ignored
    vecs[3]  = mkv(4'b1100, 9'd0,   2'b10, 9'd5, 2'b10, 4'b1000, 9'd3,   5'b11000); // adr holds, data to A
    vecs[4]  = mkv(4'b0111, 9'd511, 2'b10, 9'd5, 2'b00, 4'b0011, 9'd511, 5'b10000); // vi+fi, req_a low
    vecs[5]  = mkv(4'b0111, 9'd100, 2'b00, 9'd0, 2'b10, 4'b0001, 9'd511, 5'b11000); // DRAIN ignores vi
    vecs[6]  = mkv(4'b0100, 9'd0,   2'b00, 9'd0, 2'b00, 4'b0001, 9'd511, 5'b10000); // still waiting fo
    vecs[7]  = mkv(4'b0100, 9'd0,   2'b00, 9'd0, 2'b11, 4'b0000, 9'd511, 5'b01010); // fo cycle with data
    vecs[8]  = mkv(4'b1100, 9'd0,   2'b00, 9'd0, 2'b00, 4'b0100, 9'd511, 5'b10000); // tie -> B
    vecs[9]  = mkv(4'b1110, 9'd9,   2'b11, 9'd7, 2'b00, 4'b0011, 9'd7,   5'b10000); // B vi+fi, A noise
    vecs[10] = mkv(4'b0000, 9'd0,   2'b00, 9'd0, 2'b11, 4'b0000, 9'd7,   5'b00101); // B frame done
    vecs[11] = mkv(4'b1100, 9'd0,   2'b00, 9'd0, 2'b00, 4'b1000, 9'd7,   5'b10000); // tie -> A again
    vecs[12] = mkv(4'b0011, 9'd0,   2'b00, 9'd0, 2'b00, 4'b0011, 9'd0,   5'b10000); // into DRAIN

    clear_inputs();
    reset_x = 1'b1;
    #2 reset_x = 1'b0;
    #20;
    got = sample_out();
    chk(got == '0 && datao_a == '0 && datao_b == '0, "reset_state",
        $sformatf("outs=%h da=%h db=%h required all 0", got, datao_a, datao_b));
    @(negedge clk);
    reset_x = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      req_a = vecs[i].i.ra;  req_b = vecs[i].i.rb;
      vi_a  = vecs[i].i.via; fi_a  = vecs[i].i.fia; adr_a = vecs[i].i.adra;
      vi_b  = vecs[i].i.vib; fi_b  = vecs[i].i.fib; adr_b = vecs[i].i.adrb;
      man_vo  = vecs[i].i.rvo;
      man_fo  = vecs[i].i.rfo;
      man_dat = vecs[i].i.rvo ? SPUR : '0;
      step();
      got    = sample_out();
      exp_da = vecs[i].o.voa ? SPUR : '0;
      exp_db = vecs[i].o.vob ? SPUR : '0;
      chk(got == vecs[i].o && datao_a == exp_da && datao_b == exp_db, $sformatf("vec%0d", i),
          $sformatf("outs=%h required %h, da=%h required %h, db=%h required %h",
                    got, vecs[i].o, datao_a, exp_da, datao_b, exp_db));
    end

    // Reset while in DRAIN: outputs clear without a clock edge.
    clear_inputs();
    reset_x = 1'b0;
    #1;
    got = sample_out();
    chk(got == '0 && datao_a == '0 && datao_b == '0, "async_reset",
        $sformatf("outs=%h da=%h db=%h required all 0", got, datao_a, datao_b));
    repeat (2) step();
    reset_x = 1'b1;
    // Stale ROM completion after release must be dropped.
    man_fo = 1'b1; man_vo = 1'b1; man_dat = SPUR;
    step();
    got = sample_out();
    chk(got == '0 && datao_a == '0 && datao_b == '0, "stale_fo",
        $sformatf("outs=%h da=%h db=%h required all 0", got, datao_a, datao_b));
    clear_inputs();
    step();
    chk(!busy && !fo_a && !fo_b, "stay_idle",
        $sformatf("busy=%b fo_a=%b fo_b=%b required 0/0/0", busy, fo_a, fo_b));

    // Full-ROM sweep by A, then random frames under the behavioural ROM.
    do_reset();
    rom_auto = 1'b1;
    step();
    run_frame(1'b1, 1'b0, 512, 1'b1);
    for (int f = 0; f < 24; f++) begin
      int pat;
      pat = $urandom_range(1, 3);
      run_frame(pat[0], pat[1], $urandom_range(1, 12), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
